regfile_sb: RTL

Parametrised multi-port register file with an integrated busy scoreboard, the successor to the fixed eight-by-16-bit register bank. It provides one write port, two read ports and one reserve port. Per-register busy bits track outstanding producers so that the decode stage can stall on register hazards. Optional write-to-read bypass and an optional hardwired-zero register 0 are selectable at elaboration.

---
 rtl/regfile_sb.sv | 118 +++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register busy scoreboard.
// Reads are combinational with optional write bypass; writes and reserves land on the rising edge.
module regfile_sb #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [WIDTH-1:0]  rd0_data,
  output logic [WIDTH-1:0]  rd1_data,
  output logic              rd0_busy,
  output logic              rd1_busy,
  output logic [DEPTH-1:0]  busy_vec,
  output logic              err,
  input  logic              err_clr
);

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             err_q, err_d;

  logic [DEPTH-1:0] wr_hit, rsv_hit;
  logic             wr_ok, rsv_ok;
  logic             wr_tgt_busy, rsv_tgt_busy, same_tgt, err_set;

  logic [WIDTH-1:0] rd0_data_c, rd1_data_c;
  logic             rd0_busy_c, rd1_busy_c;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic ok;
    ok = ({1'b0, a} < DEPTH_L);
    if (ZERO_R0 != 0 && a == '0) ok = 1'b0;
    return ok;
  endfunction

  assign wr_ok  = wr_en  && addr_ok(wr_addr);
  assign rsv_ok = rsv_en && addr_ok(rsv_addr);

  always_comb begin
    wr_hit  = '0;
    rsv_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_hit[i]  = wr_ok  && (wr_addr  == ADDR_W'(i));
      rsv_hit[i] = rsv_ok && (rsv_addr == ADDR_W'(i));
    end
  end

  assign wr_tgt_busy  = |(wr_hit & busy_q);
  assign rsv_tgt_busy = |(rsv_hit & busy_q);
  assign same_tgt     = |(wr_hit & rsv_hit);

  // A reserve of a register being written in the same cycle hands it to a newer producer: not an error.
  assign err_set = (rsv_ok && rsv_tgt_busy && !same_tgt) || (wr_ok && !wr_tgt_busy);
  assign err_d   = err_set || (err_q && !err_clr);

  // Reserve beats write so a same-cycle new producer keeps the register busy.
  assign busy_d  = (busy_q & ~wr_hit) | rsv_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) regs_q[i] <= wr_data;
      end
    end
  end

  always_comb begin
    rd0_data_c = '0;
    rd0_busy_c = 1'b0;
    rd1_data_c = '0;
    rd1_busy_c = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_ok(rd0_addr) && rd0_addr == ADDR_W'(i)) begin
        rd0_data_c = regs_q[i];
        rd0_busy_c = busy_q[i];
      end
      if (addr_ok(rd1_addr) && rd1_addr == ADDR_W'(i)) begin
        rd1_data_c = regs_q[i];
        rd1_busy_c = busy_q[i];
      end
    end
    if (BYPASS != 0 && wr_ok && wr_addr == rd0_addr) begin
      rd0_data_c = wr_data;
      rd0_busy_c = 1'b0;
    end
    if (BYPASS != 0 && wr_ok && wr_addr == rd1_addr) begin
      rd1_data_c = wr_data;
      rd1_busy_c = 1'b0;
    end
  end

  // Bypass would otherwise leak wr_data while reset is held.
  assign rd0_data = rst ? rd0_data_c : '0;
  assign rd1_data = rst ? rd1_data_c : '0;
  assign rd0_busy = rst && rd0_busy_c;
  assign rd1_busy = rst && rd1_busy_c;
  assign busy_vec = busy_q;
  assign err      = err_q;

endmodule
